lfsr_decrypt_engine: RTL and testbench

- Downstream stage of the program-1 encryptor. Consumes the 64-byte encrypted frame: preamble of ASCII spaces (at least 10), then the message, then space padding.
- Each byte is 7-bit ciphertext XOR LFSR state, with even parity in bit 7.
- Recovers the tap pattern (one of 9) and the starting state from the first 10 bytes, which are known spaces, then streams out the decrypted plaintext with per-byte parity check.
- Sits between the encrypted-frame source (data memory reader) and the plaintext sink. The req/ack handshake matches the top-level program launch.

---
 rtl/lfsr_decrypt_engine.sv | 276 +++++++++++++++++++++++++++
 tb/tb_lfsr_decrypt_engine.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_decrypt_engine.sv
// rtl/lfsr_decrypt_engine.sv - LFSR frame decryptor with tap/seed recovery from a space preamble
module lfsr_decrypt_engine #(
    parameter int FRAME_LEN = 64,
    parameter int TRAIN_LEN = 10
) (
    input  logic       clk,
    input  logic       init,
    input  logic       req,
    output logic       ack,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_par_err,
    output logic       ptrn_found,
    output logic [3:0] ptrn_idx,
    output logic [6:0] err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRAIN,
        S_PICK,
        S_EMIT_PRE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [5:0] TRAIN_LAST = 6'(TRAIN_LEN - 1);
    localparam logic [5:0] FRAME_LAST = 6'(FRAME_LEN - 1);

    function automatic logic [6:0] tap_of(input logic [3:0] idx);
        case (idx)
            4'd0:    tap_of = 7'h60;
            4'd1:    tap_of = 7'h48;
            4'd2:    tap_of = 7'h78;
            4'd3:    tap_of = 7'h72;
            4'd4:    tap_of = 7'h6A;
            4'd5:    tap_of = 7'h69;
            4'd6:    tap_of = 7'h5C;
            4'd7:    tap_of = 7'h7E;
            4'd8:    tap_of = 7'h7B;
            default: tap_of = 7'h60;
        endcase
    endfunction

    function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] t);
        lfsr_step = {s[5:0], ^(s & t)};
    endfunction

    state_t                 state_q, state_d;
    logic [6:0]             cand_q [0:8];
    logic [6:0]             cand_d [0:8];
    logic [6:0]             cand_step [0:8];
    logic [8:0]             mask_q, mask_d;
    logic [TRAIN_LEN-1:0]   par_log_q, par_log_d;
    logic [6:0]             lfsr_q, lfsr_d;
    logic [5:0]             in_cnt_q, in_cnt_d;
    logic                   in_full_q, in_full_d;
    logic [5:0]             out_cnt_q, out_cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic [7:0]             out_data_q, out_data_d;
    logic                   out_par_err_q, out_par_err_d;
    logic                   ptrn_found_q, ptrn_found_d;
    logic [3:0]             ptrn_idx_q, ptrn_idx_d;
    logic [6:0]             err_cnt_q, err_cnt_d;
    logic                   ack_q, ack_d;

    logic                   in_ready_c;
    logic                   in_fire;
    logic                   out_fire;
    logic                   par_err_in;
    logic [6:0]             s_in;
    logic [3:0]             pick_idx;

    assign in_fire    = in_valid && in_ready_c;
    assign out_fire   = out_valid_q && out_ready;
    assign par_err_in = in_data[7] ^ (^in_data[6:0]);
    assign s_in       = in_data[6:0] ^ 7'h20;

    // Input acceptance: always open while training, skid-free single slot while running
    always_comb begin
        in_ready_c = 1'b0;
        case (state_q)
            S_TRAIN: in_ready_c = 1'b1;
            S_RUN:   in_ready_c = !in_full_q && (!out_valid_q || out_ready);
            default: in_ready_c = 1'b0;
        endcase
    end

    // Every candidate advanced one step with its own tap, for training and for the pick
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            cand_step[i] = lfsr_step(cand_q[i], tap_of(4'(i)));
        end
    end

    // Lowest surviving candidate wins when several taps fit the preamble
    always_comb begin
        pick_idx = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (mask_q[i]) begin
                pick_idx = 4'(i);
            end
        end
    end

    // Next-state and datapath for the whole frame sequence
    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        mask_d        = mask_q;
        par_log_d     = par_log_q;
        lfsr_d        = lfsr_q;
        in_cnt_d      = in_cnt_q;
        in_full_d     = in_full_q;
        out_cnt_d     = out_cnt_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_par_err_d = out_par_err_q;
        ptrn_found_d  = ptrn_found_q;
        ptrn_idx_d    = ptrn_idx_q;
        err_cnt_d     = err_cnt_q;
        ack_d         = ack_q;

        if (in_fire && par_err_in && (err_cnt_q != 7'h7F)) begin
            err_cnt_d = err_cnt_q + 7'd1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (req) begin
                    state_d       = S_TRAIN;
                    err_cnt_d     = 7'd0;
                    mask_d        = 9'h1FF;
                    in_cnt_d      = 6'd0;
                    in_full_d     = 1'b0;
                    out_cnt_d     = 6'd0;
                    out_valid_d   = 1'b0;
                    out_par_err_d = 1'b0;
                    ptrn_found_d  = 1'b0;
                    ptrn_idx_d    = 4'd0;
                    ack_d         = 1'b0;
                end
            end
            S_TRAIN: begin
                if (in_fire) begin
                    // Log parity oldest-first so byte 0 ends up in bit 0 after TRAIN_LEN shifts
                    par_log_d = {par_err_in, par_log_q[TRAIN_LEN-1:1]};
                    in_cnt_d  = in_cnt_q + 6'd1;
                    if (in_cnt_q == 6'd0) begin
                        for (int i = 0; i < 9; i++) begin
                            cand_d[i] = s_in;
                        end
                        if (s_in == 7'd0) begin
                            mask_d = 9'h000;
                        end
                    end else begin
                        for (int i = 0; i < 9; i++) begin
                            cand_d[i] = cand_step[i];
                            if (cand_step[i] != s_in) begin
                                mask_d[i] = 1'b0;
                            end
                        end
                    end
                    if (in_cnt_q == TRAIN_LAST) begin
                        state_d = S_PICK;
                    end
                end
            end
            S_PICK: begin
                if (mask_q != 9'h000) begin
                    ptrn_found_d  = 1'b1;
                    ptrn_idx_d    = pick_idx;
                    lfsr_d        = cand_step[pick_idx];
                    out_valid_d   = 1'b1;
                    out_data_d    = 8'h20;
                    out_par_err_d = par_log_q[0];
                    par_log_d     = par_log_q >> 1;
                    state_d       = S_EMIT_PRE;
                end else begin
                    ptrn_found_d = 1'b0;
                    ack_d        = 1'b1;
                    state_d      = S_DONE;
                end
            end
            S_EMIT_PRE: begin
                if (out_fire) begin
                    out_cnt_d = out_cnt_q + 6'd1;
                    if (out_cnt_q == TRAIN_LAST) begin
                        out_valid_d = 1'b0;
                        state_d     = S_RUN;
                    end else begin
                        out_data_d    = 8'h20;
                        out_par_err_d = par_log_q[0];
                        par_log_d     = par_log_q >> 1;
                    end
                end
            end
            S_RUN: begin
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    if (out_cnt_q == FRAME_LAST) begin
                        ack_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        out_cnt_d = out_cnt_q + 6'd1;
                    end
                end
                if (in_fire) begin
                    out_valid_d   = 1'b1;
                    out_data_d    = {1'b0, in_data[6:0] ^ lfsr_q};
                    out_par_err_d = par_err_in;
                    lfsr_d        = lfsr_step(lfsr_q, tap_of(ptrn_idx_q));
                    if (in_cnt_q == FRAME_LAST) begin
                        in_full_d = 1'b1;
                    end else begin
                        in_cnt_d = in_cnt_q + 6'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously by init
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q       <= S_IDLE;
            for (int i = 0; i < 9; i++) begin
                cand_q[i] <= 7'd0;
            end
            mask_q        <= 9'h000;
            par_log_q     <= '0;
            lfsr_q        <= 7'd0;
            in_cnt_q      <= 6'd0;
            in_full_q     <= 1'b0;
            out_cnt_q     <= 6'd0;
            out_valid_q   <= 1'b0;
            out_data_q    <= 8'h00;
            out_par_err_q <= 1'b0;
            ptrn_found_q  <= 1'b0;
            ptrn_idx_q    <= 4'd0;
            err_cnt_q     <= 7'd0;
            ack_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cand_q        <= cand_d;
            mask_q        <= mask_d;
            par_log_q     <= par_log_d;
            lfsr_q        <= lfsr_d;
            in_cnt_q      <= in_cnt_d;
            in_full_q     <= in_full_d;
            out_cnt_q     <= out_cnt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_par_err_q <= out_par_err_d;
            ptrn_found_q  <= ptrn_found_d;
            ptrn_idx_q    <= ptrn_idx_d;
            err_cnt_q     <= err_cnt_d;
            ack_q         <= ack_d;
        end
    end

    assign ack         = ack_q;
    assign in_ready    = in_ready_c;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_par_err = out_par_err_q;
    assign ptrn_found  = ptrn_found_q;
    assign ptrn_idx    = ptrn_idx_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
// tb/tb_lfsr_decrypt_engine.sv - scoreboard bench for lfsr_decrypt_engine
module tb_lfsr_decrypt_engine;

    logic       clk = 1'b0;
    logic       init;
    logic       req;
    logic       ack;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_par_err;
    logic       ptrn_found;
    logic [3:0] ptrn_idx;
    logic [6:0] err_cnt;

    lfsr_decrypt_engine dut (
        .clk         (clk),
        .init        (init),
        .req         (req),
        .ack         (ack),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_par_err (out_par_err),
        .ptrn_found  (ptrn_found),
        .ptrn_idx    (ptrn_idx),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         out_count = 0;
    int         out_cyc [64];
    logic [8:0] exp_q [$];
    bit         stall_en = 1'b0;
    bit         gap_en = 1'b0;
    bit         held_v = 1'b0;
    logic [8:0] held_d;
    logic [7:0] frame [64];
    logic [6:0] plain [64];
    bit         perr [64];
    string      msg = "Mr. Watson, come here. I want to see you.";

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] tb_tap(input int i);
        case (i)
            0: return 7'h60;
            1: return 7'h48;
            2: return 7'h78;
            3: return 7'h72;
            4: return 7'h6A;
            5: return 7'h69;
            6: return 7'h5C;
            7: return 7'h7E;
            default: return 7'h7B;
        endcase
    endfunction

    function automatic logic [6:0] tb_step(input logic [6:0] s, input logic [6:0] t);
        return {s[5:0], ^(s & t)};
    endfunction

    // no lower-indexed tap may reproduce the same 10 training states
    function automatic bit unique_tap(input int tap, input logic [6:0] s0);
        for (int j = 0; j < tap; j++) begin
            logic [6:0] sj = s0;
            logic [6:0] st = s0;
            bit same = 1'b1;
            for (int k = 1; k < 10; k++) begin
                sj = tb_step(sj, tb_tap(j));
                st = tb_step(st, tb_tap(tap));
                if (sj != st) same = 1'b0;
            end
            if (same) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [6:0] pick_init(input int tap);
        logic [6:0] s;
        do s = 7'($urandom_range(1, 127)); while (!unique_tap(tap, s));
        return s;
    endfunction

    task automatic build_frame(input int tap, input logic [6:0] s0, input int pre,
                               input string m, input int fa, input int fb);
        logic [6:0] s = s0;
        logic [6:0] c;
        byte        b;
        for (int i = 0; i < 64; i++) begin
            if (i >= pre && (i - pre) < m.len()) begin
                b = m[i - pre];
                plain[i] = b[6:0];
            end else begin
                plain[i] = 7'h20;
            end
            perr[i]  = (i == fa) || (i == fb);
            c        = plain[i] ^ s;
            frame[i] = {(^c) ^ perr[i], c};
            s        = tb_step(s, tb_tap(tap));
        end
    endtask

    // output side: decide out_ready, then score the byte that will move on the next edge
    always @(negedge clk) begin
        if (init) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                checks++;
                if (!out_valid || {out_par_err, out_data} !== held_d) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%0b data=%h required valid=1 data=%h",
                             out_valid, {out_par_err, out_data}, held_d);
                end
            end
            out_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: data=%h with empty scoreboard",
                             {out_par_err, out_data});
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    if ({out_par_err, out_data} !== e) begin
                        errors++;
                        $display("FAIL out_byte %0d: got %h required %h",
                                 out_count, {out_par_err, out_data}, e);
                    end
                end
                if (out_count < 64) out_cyc[out_count] = cyc;
                out_count++;
                held_v = 1'b0;
            end else begin
                held_v = out_valid;
                held_d = {out_par_err, out_data};
            end
        end
    end

    task automatic start_frame();
        @(negedge clk); #1 req = 1'b1;
        @(negedge clk); #1 req = 1'b0;
    endtask

    task automatic send_bytes(input int n, input bit push, input int abort_at,
                              output int last_cyc);
        int i = 0;
        int stall_cnt = 0;
        bit aborted = 1'b0;
        last_cyc = cyc;
        while (i < n) begin
            @(negedge clk); #1;
            if (abort_at > 0 && out_count >= abort_at) begin
                aborted = 1'b1;
                break;
            end
            if (gap_en && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = frame[i];
            end
            #1;
            if (in_valid && in_ready) begin
                if (push) exp_q.push_back({perr[i], 1'b0, plain[i]});
                last_cyc  = cyc;
                i++;
                stall_cnt = 0;
            end else begin
                stall_cnt++;
                if (stall_cnt > 500) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: byte %0d not accepted, required acceptance", i);
                    break;
                end
            end
        end
        if (!aborted) @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_ack(input int budget);
        int n = 0;
        while (!ack && n < budget) begin
            @(negedge clk); #2;
            n++;
        end
    endtask

    task automatic run_frame(input int tap, input logic [6:0] s0, input int pre,
                             input int fa, input int fb, input int exp_err);
        int lc;
        build_frame(tap, s0, pre, msg, fa, fb);
        out_count = 0;
        start_frame();
        send_bytes(64, 1'b1, 0, lc);
        wait_ack(400);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL frame_ack tap %0d: got %b required 1", tap, ack); end
        checks++;
        if (out_count != 64) begin errors++; $display("FAIL frame_count tap %0d: got %0d required 64", tap, out_count); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL frame_left tap %0d: got %0d required 0", tap, exp_q.size()); end
        checks++;
        if (ptrn_found !== 1'b1 || ptrn_idx !== 4'(tap)) begin
            errors++;
            $display("FAIL frame_ptrn: got found=%b idx=%0d required found=1 idx=%0d", ptrn_found, ptrn_idx, tap);
        end
        checks++;
        if (err_cnt !== 7'(exp_err)) begin errors++; $display("FAIL frame_err_cnt tap %0d: got %0d required %0d", tap, err_cnt, exp_err); end
        exp_q.delete();
    endtask

    task automatic test_reset();
        init = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        checks++;
        if ({ack, in_ready, out_valid, out_par_err, ptrn_found} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00000", {ack, in_ready, out_valid, out_par_err, ptrn_found});
        end
        checks++;
        if (out_data !== 8'h00 || ptrn_idx !== 4'd0 || err_cnt !== 7'd0) begin
            errors++;
            $display("FAIL reset_values: data=%h idx=%0d err=%0d required 0", out_data, ptrn_idx, err_cnt);
        end
        @(negedge clk); #1 init = 1'b0;
        @(negedge clk); #2;
        checks++;
        if (in_ready !== 1'b0 || ack !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: in_ready=%b ack=%b required 0 0", in_ready, ack);
        end
    endtask

    task automatic test_all_space();
        run_frame(0, 7'h01, 64, -1, -1, 0);
    endtask

    task automatic test_message();
        for (int t = 0; t < 9; t++) run_frame(t, pick_init(t), 12, -1, -1, 0);
    endtask

    task automatic test_parity();
        run_frame(4, pick_init(4), 12, 3, 40, 2);
    endtask

    task automatic test_stalls();
        stall_en = 1'b1;
        gap_en   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int t = $urandom_range(0, 8);
            run_frame(t, pick_init(t), 12, -1, -1, 0);
        end
        stall_en = 1'b0;
        gap_en   = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_frame(7, pick_init(7), 12, -1, -1, 0);
        checks++;
        if (out_cyc[9] - out_cyc[0] != 9) begin
            errors++;
            $display("FAIL preamble_rate: got %0d cycles required 9", out_cyc[9] - out_cyc[0]);
        end
        checks++;
        if (out_cyc[63] - out_cyc[10] != 53) begin
            errors++;
            $display("FAIL run_rate: got %0d cycles required 53", out_cyc[63] - out_cyc[10]);
        end
    endtask

    task automatic test_no_match();
        int lc;
        logic [6:0] c;
        build_frame(2, pick_init(2), 12, msg, -1, -1);
        c        = frame[5][6:0] ^ 7'h7F;
        frame[5] = {^c, c};
        out_count = 0;
        exp_q.delete();
        start_frame();
        send_bytes(10, 1'b0, 0, lc);
        wait_ack(20);
        checks++;
        if (ack !== 1'b1 || (cyc - lc) > 12) begin
            errors++;
            $display("FAIL nomatch_ack: ack=%b after %0d cycles required 1 within 12", ack, cyc - lc);
        end
        checks++;
        if (ptrn_found !== 1'b0) begin errors++; $display("FAIL nomatch_found: got %b required 0", ptrn_found); end
        repeat (3) @(negedge clk);
        checks++;
        if (out_count != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL nomatch_output: got %0d outputs required 0", out_count);
        end
    endtask

    task automatic test_abort();
        int lc;
        build_frame(3, pick_init(3), 12, msg, 3, -1);
        out_count = 0;
        start_frame();
        send_bytes(64, 1'b1, 30, lc);
        checks++;
        if (err_cnt !== 7'd1) begin errors++; $display("FAIL abort_err_mid: got %0d required 1", err_cnt); end
        init = 1'b1;
        #1;
        checks++;
        if ({ack, in_ready, out_valid, out_par_err, ptrn_found} !== 5'b0 ||
            out_data !== 8'h00 || ptrn_idx !== 4'd0 || err_cnt !== 7'd0) begin
            errors++;
            $display("FAIL abort_reset: flags=%b data=%h idx=%0d err=%0d required all 0",
                     {ack, in_ready, out_valid, out_par_err, ptrn_found}, out_data, ptrn_idx, err_cnt);
        end
        exp_q.delete();
        @(negedge clk); #1 init = 1'b0;
        run_frame(5, pick_init(5), 12, 40, -1, 1);
    endtask

    initial begin
        init     = 1'b1;
        req      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_all_space();
        test_message();
        test_parity();
        test_stalls();
        test_back_to_back();
        test_no_match();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
